// File: rtl/pipeline_pkg.sv
// Shared encodings for the MIPS pipeline: PC-source selects, fetch FSM states, nop word.
package pipeline_pkg;

   typedef enum logic [2:0] {
      PCSRC_SEQ   = 3'b000,
      PCSRC_BR    = 3'b001,
      PCSRC_J     = 3'b010,
      PCSRC_JR    = 3'b011,
      PCSRC_ILLOP = 3'b100,
      PCSRC_XADR  = 3'b101
   } pcsrc_e;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DRAIN = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: reset, then flush, then load-or-bubble, otherwise hold.
module if_id_reg
   import pipeline_pkg::*;
(
   input  logic        clk,
   input  logic        rst_ni,
   input  logic        clear_ni,
   input  logic        wr_i,
   input  logic        valid_i,
   input  logic [31:0] pc_plus4_i,
   input  logic [31:0] instr_i,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] instr_o,
   output logic        valid_o
);

   logic [31:0] pc_plus4_q;
   logic [31:0] instr_q;
   logic        valid_q;

   always_ff @(posedge clk) begin
      if (!rst_ni || !clear_ni) begin
         pc_plus4_q <= 32'h0;
         instr_q    <= NOP_INSTR;
         valid_q    <= 1'b0;
      end else if (wr_i) begin
         // With nothing deliverable this edge, a write becomes a bubble.
         pc_plus4_q <= valid_i ? pc_plus4_i : 32'h0;
         instr_q    <= valid_i ? instr_i : NOP_INSTR;
         valid_q    <= valid_i;
      end
   end

   assign pc_plus4_o = pc_plus4_q;
   assign instr_o    = instr_q;
   assign valid_o    = valid_q;

endmodule

// File: rtl/pipeline_fetch_stage.sv
// IF stage: PC register, next-PC select, imem request/ready handshake with skid buffer, IF/ID register.
module pipeline_fetch_stage
   import pipeline_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h8000_0000,
   parameter logic [31:0] ILLOP_PC = 32'h8000_0004,
   parameter logic [31:0] XADR_PC  = 32'h8000_0008
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCWr,
   input  logic        IF_ID_Wr,
   input  logic        IF_ID_clear,
   input  logic [2:0]  PCSrc,
   input  logic [31:0] branch_target,
   input  logic [31:0] jump_target,
   input  logic [31:0] jr_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] IF_ID_PC_plus4,
   output logic [31:0] IF_ID_Instr,
   output logic        IF_ID_valid
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  buf_pc4_q, buf_pc4_d;
   logic [31:0]  buf_instr_q, buf_instr_d;
   logic [31:0]  saved_q, saved_d;

   logic [31:0]  pc_plus4;
   logic [31:0]  target;
   logic         redirect;
   logic         deliver_valid;
   logic [31:0]  deliver_pc4;
   logic [31:0]  deliver_instr;

   assign pc_plus4  = pc_q + 32'd4;
   assign imem_req  = reset & (state_q != HOLD);
   assign imem_addr = pc_q;

   // Undefined selects 110/111 behave as sequential, so they never redirect.
   assign redirect = PCWr && (PCSrc != PCSRC_SEQ) && (PCSrc <= PCSRC_XADR);

   always_comb begin
      target = pc_plus4;
      case (PCSrc)
         PCSRC_BR:    target = branch_target;
         PCSRC_J:     target = jump_target;
         PCSRC_JR:    target = jr_target;
         PCSRC_ILLOP: target = ILLOP_PC;
         PCSRC_XADR:  target = XADR_PC;
         default:     target = pc_plus4;
      endcase
   end

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      buf_pc4_d     = buf_pc4_q;
      buf_instr_d   = buf_instr_q;
      saved_d       = saved_q;
      deliver_valid = 1'b0;
      deliver_pc4   = pc_plus4;
      deliver_instr = imem_rdata;
      case (state_q)
         FETCH: begin
            if (imem_ready) begin
               if (redirect) begin
                  pc_d = target;
               end else begin
                  if (IF_ID_Wr) begin
                     deliver_valid = 1'b1;
                  end else begin
                     buf_pc4_d   = pc_plus4;
                     buf_instr_d = imem_rdata;
                     state_d     = HOLD;
                  end
                  if (PCWr) pc_d = pc_plus4;
               end
            end else if (redirect) begin
               saved_d = target;
               state_d = DRAIN;
            end
         end
         HOLD: begin
            deliver_pc4   = buf_pc4_q;
            deliver_instr = buf_instr_q;
            if (redirect) begin
               pc_d    = target;
               state_d = FETCH;
            end else if (IF_ID_Wr) begin
               // Resume after the buffered word whether or not PC advanced when it was parked.
               deliver_valid = 1'b1;
               pc_d          = buf_pc4_q;
               state_d       = FETCH;
            end
         end
         DRAIN: begin
            if (imem_ready) begin
               pc_d    = redirect ? target : saved_q;
               state_d = FETCH;
            end else if (redirect) begin
               saved_d = target;
            end
         end
         default: state_d = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         buf_pc4_q   <= 32'h0;
         buf_instr_q <= NOP_INSTR;
         saved_q     <= 32'h0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         buf_pc4_q   <= buf_pc4_d;
         buf_instr_q <= buf_instr_d;
         saved_q     <= saved_d;
      end
   end

   if_id_reg u_if_id_reg (
      .clk        (clk),
      .rst_ni     (reset),
      .clear_ni   (IF_ID_clear),
      .wr_i       (IF_ID_Wr),
      .valid_i    (deliver_valid),
      .pc_plus4_i (deliver_pc4),
      .instr_i    (deliver_instr),
      .pc_plus4_o (IF_ID_PC_plus4),
      .instr_o    (IF_ID_Instr),
      .valid_o    (IF_ID_valid)
   );

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Cycle-by-cycle bench for pipeline_fetch_stage with a scoreboard of expected IF/ID contents.
module tb_pipeline_fetch_stage;

   localparam logic [31:0] A  = 32'h8000_0000;
   localparam logic [2:0]  S  = 3'b000;
   localparam logic [2:0]  BR = 3'b001;
   localparam logic [2:0]  J  = 3'b010;
   localparam logic [2:0]  JR = 3'b011;
   localparam logic [2:0]  XA = 3'b101;

   logic        clk;
   logic        reset;
   logic        PCWr;
   logic        IF_ID_Wr;
   logic        IF_ID_clear;
   logic [2:0]  PCSrc;
   logic [31:0] branch_target;
   logic [31:0] jump_target;
   logic [31:0] jr_target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_ready;
   logic [31:0] IF_ID_PC_plus4;
   logic [31:0] IF_ID_Instr;
   logic        IF_ID_valid;

   typedef struct packed {
      logic        v;
      logic [31:0] pc4;
      logic [31:0] instr;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   pipeline_fetch_stage dut (
      .clk            (clk),
      .reset          (reset),
      .PCWr           (PCWr),
      .IF_ID_Wr       (IF_ID_Wr),
      .IF_ID_clear    (IF_ID_clear),
      .PCSrc          (PCSrc),
      .branch_target  (branch_target),
      .jump_target    (jump_target),
      .jr_target      (jr_target),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_rdata     (imem_rdata),
      .imem_ready     (imem_ready),
      .IF_ID_PC_plus4 (IF_ID_PC_plus4),
      .IF_ID_Instr    (IF_ID_Instr),
      .IF_ID_valid    (IF_ID_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {~a[15:0], a[15:0]};
   endfunction

   // Memory model: word is a function of the address; garbage while not ready.
   assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp)
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic cyc(input string tag, input logic rst_n, input logic pcwr, input logic ifwr,
                      input logic clr_n, input logic [2:0] src, input logic rdy,
                      input logic exp_req, input logic [31:0] exp_addr,
                      input logic exp_v, input logic [31:0] exp_pc4);
      exp_t e;
      @(negedge clk);
      reset       = rst_n;
      PCWr        = pcwr;
      IF_ID_Wr    = ifwr;
      IF_ID_clear = clr_n;
      PCSrc       = src;
      imem_ready  = rdy;
      #1;
      check($sformatf("%s.req", tag), {31'h0, imem_req}, {31'h0, exp_req});
      if (exp_req) check($sformatf("%s.addr", tag), imem_addr, exp_addr);
      sb.push_back('{v: exp_v, pc4: exp_pc4, instr: exp_v ? mem_word(exp_pc4 - 32'd4) : 32'h0});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check($sformatf("%s.valid", tag), {31'h0, IF_ID_valid}, {31'h0, e.v});
      check($sformatf("%s.pc4", tag), IF_ID_PC_plus4, e.pc4);
      check($sformatf("%s.instr", tag), IF_ID_Instr, e.instr);
      $display("cycle %-8s req=%0b addr=%h -> valid=%0b pc4=%h instr=%h",
               tag, exp_req, exp_addr, IF_ID_valid, IF_ID_PC_plus4, IF_ID_Instr);
   endtask

   initial begin
      reset = 1'b0; PCWr = 1'b1; IF_ID_Wr = 1'b1; IF_ID_clear = 1'b1; PCSrc = S;
      branch_target = 32'h0; jump_target = 32'h0; jr_target = 32'h0; imem_ready = 1'b1;

      //   tag        rst pcw wr clr src rdy  req addr              v  pc4
      cyc("rst0",     0,  1,  1, 1,  S,  1,   0,  32'h0,            0, 32'h0);
      cyc("rst1",     0,  1,  1, 1,  S,  1,   0,  32'h0,            0, 32'h0);
      cyc("seq0",     1,  1,  1, 1,  S,  1,   1,  A,                1, A + 32'h4);
      cyc("seq1",     1,  1,  1, 1,  S,  1,   1,  A + 32'h4,        1, A + 32'h8);
      cyc("seq2",     1,  1,  1, 1,  S,  1,   1,  A + 32'h8,        1, A + 32'hC);
      cyc("stall",    1,  0,  0, 1,  S,  1,   1,  A + 32'hC,        1, A + 32'hC);
      cyc("hold",     1,  1,  1, 1,  S,  1,   0,  32'h0,            1, A + 32'h10);
      cyc("resume",   1,  1,  1, 1,  S,  1,   1,  A + 32'h10,       1, A + 32'h14);
      branch_target = A + 32'h40;
      cyc("branch",   1,  1,  1, 0,  BR, 1,   1,  A + 32'h14,       0, 32'h0);
      cyc("brtgt",    1,  1,  1, 1,  S,  1,   1,  A + 32'h40,       1, A + 32'h44);
      cyc("xadr",     1,  1,  1, 0,  XA, 1,   1,  A + 32'h44,       0, 32'h0);
      cyc("wait0",    1,  1,  1, 1,  S,  0,   1,  A + 32'h8,        0, 32'h0);
      cyc("wait1",    1,  1,  1, 1,  S,  0,   1,  A + 32'h8,        0, 32'h0);
      cyc("wdone",    1,  1,  1, 1,  S,  1,   1,  A + 32'h8,        1, A + 32'hC);
      jr_target = A + 32'h100;
      cyc("jrwait",   1,  1,  1, 1,  JR, 0,   1,  A + 32'hC,        0, 32'h0);
      cyc("drain",    1,  1,  1, 1,  S,  0,   1,  A + 32'hC,        0, 32'h0);
      cyc("drdone",   1,  1,  1, 1,  S,  1,   1,  A + 32'hC,        0, 32'h0);
      cyc("jrtgt",    1,  1,  1, 1,  S,  1,   1,  A + 32'h100,      1, A + 32'h104);
      jr_target = A + 32'h200;
      cyc("jr2",      1,  1,  1, 1,  JR, 0,   1,  A + 32'h104,      0, 32'h0);
      cyc("xadr2",    1,  1,  1, 1,  XA, 0,   1,  A + 32'h104,      0, 32'h0);
      cyc("dr2done",  1,  1,  1, 1,  S,  1,   1,  A + 32'h104,      0, 32'h0);
      cyc("xtgt",     1,  1,  1, 1,  S,  1,   1,  A + 32'h8,        1, A + 32'hC);
      cyc("brwait",   1,  1,  1, 1,  BR, 0,   1,  A + 32'hC,        0, 32'h0);
      cyc("mrst0",    0,  1,  1, 1,  S,  1,   0,  32'h0,            0, 32'h0);
      cyc("mrst1",    0,  1,  1, 1,  S,  1,   0,  32'h0,            0, 32'h0);
      cyc("post",     1,  1,  1, 1,  S,  1,   1,  A,                1, A + 32'h4);
      cyc("stall2",   1,  0,  0, 1,  S,  1,   1,  A + 32'h4,        1, A + 32'h4);
      jump_target = A + 32'h300;
      cyc("holdj",    1,  1,  1, 1,  J,  1,   0,  32'h0,            0, 32'h0);
      cyc("jtgt",     1,  1,  1, 1,  S,  1,   1,  A + 32'h300,      1, A + 32'h304);
      jump_target = 32'hFFFF_FFFC;
      cyc("jwrap",    1,  1,  1, 1,  J,  1,   1,  A + 32'h304,      0, 32'h0);
      cyc("top",      1,  1,  1, 1,  S,  1,   1,  32'hFFFF_FFFC,    1, 32'h0);
      cyc("wrap",     1,  1,  1, 1,  S,  1,   1,  32'h0,            1, 32'h4);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
